// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;
    localparam int XLEN    = 32;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    localparam logic [5:0] OP_STOP = 6'b111111;

    typedef enum logic [2:0] {IDLE, REQ, VALID, HALT, FAULT} state_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack plus the decode handshake.
interface ifetch_unit_if;
    import ifetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            jump;
    logic            branch_taken;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, jump, branch_taken
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready, jump, branch_taken
    );
endinterface

// File: rtl/ifetch_unit_next_pc_calc.sv
// Next-PC selection for the retiring instruction: jump > taken branch > sequential.
module next_pc_calc
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0]    pc,
    input  logic [JADDR_W-1:0] instr,
    input  logic               jump,
    input  logic               branch_taken,
    output logic [XLEN-1:0]    pcplus4,
    output logic [XLEN-1:0]    npc
);
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] j_tgt;

    // Opcode bits play no part here, so only the low 26 instruction bits come in.
    assign pcplus4 = pc + 32'd4;
    assign br_off  = {{(XLEN-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    assign j_tgt   = {pcplus4[XLEN-1:JADDR_W+2], instr, 2'b00};

    always_comb begin
        npc = pcplus4;
        if (jump)
            npc = j_tgt;
        else if (branch_taken)
            npc = pcplus4 + br_off;
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, imem request FSM with timeout watchdog,
// single-entry instruction holding register toward decode.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    ifetch_unit_if.master   bus,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            halted,
    output logic            fault
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic            req_q;
    logic            vld_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] npc;

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = vld_q;

    next_pc_calc u_npc (
        .pc           (pc),
        .instr        (instr_q[JADDR_W-1:0]),
        .jump         (bus.jump),
        .branch_taken (bus.branch_taken),
        .pcplus4      (pcplus4),
        .npc          (npc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            req_q   <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        tmo_cnt <= '0;
                        req_q   <= 1'b0;
                        // The stop word is never handed to decode.
                        if (bus.imem_rdata[31:26] == OP_STOP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state   <= VALID;
                            instr_q <= bus.imem_rdata;
                            vld_q   <= 1'b1;
                        end
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        req_q <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                VALID: begin
                    if (bus.instr_ready) begin
                        pc    <= npc;
                        vld_q <= 1'b0;
                        req_q <= 1'b1;
                        state <= REQ;
                    end
                end
                HALT, FAULT: state <= state;
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
